timer_multi: RTL and testbench
==============================

Name: timer_multi

Overview:
- Parametrised successor to the SoC's fixed timer: one up-counter with programmable TOP, N_MATCH compare channels and a power-of-two prescaler.
- Mapped on the CPU data-memory/IO bus (address, din, dout, w_en, r_en).
- Drives one interrupt flag per event (top, match0..matchN-1) with the CPU's flag/clear handshake, so it plugs straight into the cpu interrupt_k / interrupt_k_clr pins.

Parameters:
- WIDTH, 8: counter/TOP/MATCH width; legal 1..16.
- N_MATCH, 2: number of compare channels; legal 1..4.
- BASE_ADDR, 16'h0010: bus base address; must be 16-aligned.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- address  in  16  CPU data/IO address
- din  in  8  CPU write data
- w_en  in  1  write strobe, one cycle
- r_en  in  1  read strobe, one cycle
- dout  out  8  read data; 0 when not selected
- top_flag  out  1  counter reached TOP
- top_flag_clr  in  1  clear pulse from CPU interrupt acknowledge
- match_flag  out  N_MATCH  per-channel compare flag
- match_flag_clr  in  N_MATCH  per-channel clear pulse
- pwm_out  out  N_MATCH  PWM outputs (optional feature)

Behaviour:
- Reset (async, rst=1): all registers 0; dout=0, top_flag=0, match_flag=0, pwm_out=0, counter stopped.
- Select: sel = (address[15:4] == BASE_ADDR[15:4]). Offset = address[3:0].
- Register map:
  - 0x0 CTRL: bit0 EN, bit1 ONESHOT, bits5:2 PS.
  - 0x1 STATUS: bit0 top_flag, bits N_MATCH:1 match_flag. Writing 1 clears that bit; writing 0 has no effect.
  - 0x2/0x3 COUNT_L/H.
  - 0x4/0x5 TOP_L/H.
  - 0x6+2k / 0x7+2k MATCHk_L/H.
  - Unimplemented offsets read 0; writes to them are ignored.
  - Bits at or above WIDTH read 0 and are ignored on write. If WIDTH<=8, H registers read 0.
- Read latency: dout is registered, valid the cycle after r_en & sel. If r_en=0 or sel=0, dout=0 on the next cycle (bus OR-able).
- 16-bit atomicity (WIDTH>8):
  - Writing COUNT_H stores temp_hi only. Writing COUNT_L loads count={temp_hi,din} and resets the prescaler.
  - Reading COUNT_L snapshots count[15:8] into rd_hi. Reading COUNT_H returns rd_hi.
  - TOP and MATCH H/L writes take effect immediately, byte-wise.
- Prescaler: 16-bit pre_cnt runs while EN=1. tick=1 when pre_cnt == 2^PS-1, then pre_cnt wraps to 0. PS>15 saturates to 15. PS=0 gives tick every cycle.
- Counting, on tick:
  - if count==TOP: count<=0, set top_flag; if ONESHOT, clear EN.
  - else count<=count+1.
  - TOP=0: counter holds 0 and top_flag sets every tick.
- Compare: on tick, for each k, count (pre-update value) == MATCHk sets match_flag[k]. MATCHk > TOP never fires.
- Flags are sticky until cleared by the clr port pulse or a STATUS write-1.
  - Set and clear in the same cycle: set wins.
- EN=0: prescaler and counter hold; flags hold.
- Write to COUNT_L coinciding with a tick: the write wins; no flag set that cycle.
- Reset mid-operation: everything returns to reset values immediately (async).

Optional Feature:
- Macro: TIMER_MULTI_PWM_EN.
- Defined: pwm_out[k] is registered, updated every cycle, and equals (EN && count < MATCHk). MATCHk=0 gives constant 0. MATCHk>TOP gives constant 1 while EN=1.
- Undefined: pwm_out is tied 0 and no compare-for-PWM logic is built. The port is always present.

Test Plan:
- Reset/readback: assert rst mid-count with EN=1, count=5 -> all flags 0, dout 0, COUNT reads 0 after release; write TOP_L=0xA5, read offset 0x4 -> dout=0xA5 one cycle after r_en.
- Free-run wrap: WIDTH=8, TOP=3, PS=0, EN=1 -> count 0,1,2,3,0; top_flag rises on the tick where count 3->0 and stays set until top_flag_clr pulse.
- Prescale + match: PS=2, TOP=9, MATCH0=4 -> count advances every 4 cycles; match_flag[0] sets on the tick with count=4; match_flag[1] (MATCH1=0) sets on the count=0 tick.
- Handshake collision: hold match condition and pulse match_flag_clr[0] in the same cycle -> flag stays 1; STATUS write 0x02 on a later cycle -> match_flag[0]=0, top_flag unaffected.
- One-shot + 16-bit: WIDTH=16, ONESHOT=1, TOP=0x0102 -> top_flag sets once, EN reads 0, count 0 held; write COUNT_H=0x12 then COUNT_L=0x34 -> reads 0x34 then 0x12.
- PWM (macro on): TOP=7, MATCH0=3, PS=0 -> pwm_out[0] high 3 of every 8 cycles; macro off -> pwm_out=0 throughout.

Source files
------------

// File: rtl/timer_multi.sv
// Multi-channel timer: prescaled up-counter with programmable TOP, N_MATCH compare
// channels and sticky interrupt flags. Define TIMER_MULTI_PWM_EN to build the PWM outputs.
module timer_multi #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned N_MATCH   = 2,
  parameter logic [15:0] BASE_ADDR = 16'h0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        address,
  input  logic [7:0]         din,
  input  logic               w_en,
  input  logic               r_en,
  output logic [7:0]         dout,
  output logic               top_flag,
  input  logic               top_flag_clr,
  output logic [N_MATCH-1:0] match_flag,
  input  logic [N_MATCH-1:0] match_flag_clr,
  output logic [N_MATCH-1:0] pwm_out
);

  logic                            en_q, en_d, oneshot_q, oneshot_d;
  logic [3:0]                      ps_q, ps_d;
  logic [WIDTH-1:0]                count_q, count_d, top_q, top_d;
  logic [N_MATCH-1:0][WIDTH-1:0]   match_q, match_d;
  logic [7:0]                      temp_hi_q, temp_hi_d, rd_hi_q, rd_hi_d, dout_q, dout_d;
  logic [15:0]                     pre_cnt_q, pre_cnt_d;
  logic                            top_flag_q, top_flag_d;
  logic [N_MATCH-1:0]              match_flag_q, match_flag_d;

  logic                            sel, wr, rd, tick, count_wr, top_set, st_clr_top;
  logic [3:0]                      off;
  logic [15:0]                     pre_mask, count_ext, top_ext;
  logic [N_MATCH-1:0][15:0]        match_ext;
  logic [N_MATCH-1:0]              match_set, st_clr_match;
  logic [7:0]                      rdata;

  assign sel       = (address[15:4] == BASE_ADDR[15:4]);
  assign off       = address[3:0];
  assign wr        = w_en && sel;
  assign rd        = r_en && sel;
  assign count_wr  = wr && (off == 4'h2);
  assign count_ext = 16'(count_q);
  assign top_ext   = 16'(top_q);
  assign pre_mask  = (16'd1 << ps_q) - 16'd1;
  assign tick      = en_q && (pre_cnt_q == pre_mask);

  always_comb begin
    for (int k = 0; k < N_MATCH; k++) begin
      match_ext[k] = 16'(match_q[k]);
    end
  end

  // Counter, flags and register writes; bus writes are applied last so they win.
  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    ps_d      = ps_q;
    count_d   = count_q;
    top_d     = top_q;
    match_d   = match_q;
    temp_hi_d = temp_hi_q;
    pre_cnt_d = pre_cnt_q;
    top_set   = 1'b0;
    match_set = '0;

    if (en_q) begin
      pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
    end

    if (tick && !count_wr) begin
      if (count_q == top_q) begin
        count_d = '0;
        top_set = 1'b1;
        if (oneshot_q) begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q + WIDTH'(1);
      end
      for (int k = 0; k < N_MATCH; k++) begin
        match_set[k] = (count_q == match_q[k]) && (match_q[k] <= top_q);
      end
    end

    if (wr) begin
      case (off)
        4'h0: begin
          en_d      = din[0];
          oneshot_d = din[1];
          ps_d      = din[5:2];
        end
        4'h2: begin
          count_d   = WIDTH'({temp_hi_q, din});
          pre_cnt_d = 16'd0;
        end
        4'h3: temp_hi_d = din;
        4'h4: top_d = WIDTH'({top_ext[15:8], din});
        4'h5: top_d = WIDTH'({din, top_ext[7:0]});
        default: begin
          for (int k = 0; k < N_MATCH; k++) begin
            if (off == 4'(6 + 2 * k)) begin
              match_d[k] = WIDTH'({match_ext[k][15:8], din});
            end else if (off == 4'(7 + 2 * k)) begin
              match_d[k] = WIDTH'({din, match_ext[k][7:0]});
            end
          end
        end
      endcase
    end

    st_clr_top   = wr && (off == 4'h1) && din[0];
    st_clr_match = (wr && (off == 4'h1)) ? din[N_MATCH:1] : '0;
    top_flag_d   = top_set | (top_flag_q & ~top_flag_clr & ~st_clr_top);
    match_flag_d = match_set | (match_flag_q & ~match_flag_clr & ~st_clr_match);
  end

  // Read mux; a COUNT_L read latches the high byte so a following COUNT_H read is coherent.
  always_comb begin
    rdata   = '0;
    rd_hi_d = rd_hi_q;
    case (off)
      4'h0: rdata = {2'b00, ps_q, oneshot_q, en_q};
      4'h1: rdata = 8'({match_flag_q, top_flag_q});
      4'h2: rdata = count_ext[7:0];
      4'h3: rdata = rd_hi_q;
      4'h4: rdata = top_ext[7:0];
      4'h5: rdata = top_ext[15:8];
      default: begin
        for (int k = 0; k < N_MATCH; k++) begin
          if (off == 4'(6 + 2 * k)) begin
            rdata = match_ext[k][7:0];
          end else if (off == 4'(7 + 2 * k)) begin
            rdata = match_ext[k][15:8];
          end
        end
      end
    endcase
    if (rd && (off == 4'h2)) begin
      rd_hi_d = count_ext[15:8];
    end
    dout_d = rd ? rdata : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q         <= 1'b0;
      oneshot_q    <= 1'b0;
      ps_q         <= '0;
      count_q      <= '0;
      top_q        <= '0;
      match_q      <= '0;
      temp_hi_q    <= '0;
      rd_hi_q      <= '0;
      dout_q       <= '0;
      pre_cnt_q    <= '0;
      top_flag_q   <= 1'b0;
      match_flag_q <= '0;
    end else begin
      en_q         <= en_d;
      oneshot_q    <= oneshot_d;
      ps_q         <= ps_d;
      count_q      <= count_d;
      top_q        <= top_d;
      match_q      <= match_d;
      temp_hi_q    <= temp_hi_d;
      rd_hi_q      <= rd_hi_d;
      dout_q       <= dout_d;
      pre_cnt_q    <= pre_cnt_d;
      top_flag_q   <= top_flag_d;
      match_flag_q <= match_flag_d;
    end
  end

  assign dout       = dout_q;
  assign top_flag   = top_flag_q;
  assign match_flag = match_flag_q;

`ifdef TIMER_MULTI_PWM_EN
  logic [N_MATCH-1:0] pwm_q, pwm_d;

  always_comb begin
    for (int k = 0; k < N_MATCH; k++) begin
      pwm_d[k] = en_q && (count_q < match_q[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;
`else
  assign pwm_out = '0;
`endif

endmodule

// File: tb/tb_timer_multi.sv
// Scoreboard bench for timer_multi: bus reads push expected data/flags, a monitor checks them
// on the falling edge after the registered response appears.
module tb_timer_multi;

  localparam logic [15:0] Base = 16'h0010;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] address;
  logic [7:0]  din, dout;
  logic        w_en, r_en, top_flag, top_flag_clr;
  logic [1:0]  match_flag, match_flag_clr, pwm_out;

  typedef struct {
    string      name;
    logic [7:0] dout;
    bit         chk_flags;
    logic       top;
    logic [1:0] match;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  logic rd_seen;

  timer_multi #(
    .WIDTH    (16),
    .N_MATCH  (2),
    .BASE_ADDR(Base)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .address       (address),
    .din           (din),
    .w_en          (w_en),
    .r_en          (r_en),
    .dout          (dout),
    .top_flag      (top_flag),
    .top_flag_clr  (top_flag_clr),
    .match_flag    (match_flag),
    .match_flag_clr(match_flag_clr),
    .pwm_out       (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read strobe seen at an edge means dout holds a response now.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= r_en;
  end

  always @(negedge clk) begin
    if (rd_seen) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 16'd1, 16'd0);
      end else begin
        mon_e = sb.pop_front();
        chk(mon_e.name, {8'h00, dout}, {8'h00, mon_e.dout});
        if (mon_e.chk_flags) begin
          chk({mon_e.name, "_top"}, {15'd0, top_flag}, {15'd0, mon_e.top});
          chk({mon_e.name, "_match"}, {14'd0, match_flag}, {14'd0, mon_e.match});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] off, input logic [7:0] data);
    address = Base | {12'h000, off};
    din     = data;
    w_en    = 1'b1;
    @(posedge clk);
    #1;
    w_en = 1'b0;
  endtask

  task automatic rda(input logic [15:0] addr, input logic [7:0] exp, input string name);
    exp_t e;
    e.name = name; e.dout = exp; e.chk_flags = 1'b0; e.top = 1'b0; e.match = 2'b00;
    sb.push_back(e);
    address = addr;
    r_en    = 1'b1;
    @(posedge clk);
    #1;
    r_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, input logic [7:0] exp, input string name);
    rda(Base | {12'h000, off}, exp, name);
  endtask

  // Read plus flag check, optionally pulsing the clear ports on the same edge.
  task automatic rdfc(input logic [3:0] off, input logic [7:0] exp, input logic et,
                      input logic [1:0] em, input logic ct, input logic [1:0] cm,
                      input string name);
    exp_t e;
    e.name = name; e.dout = exp; e.chk_flags = 1'b1; e.top = et; e.match = em;
    sb.push_back(e);
    address        = Base | {12'h000, off};
    r_en           = 1'b1;
    top_flag_clr   = ct;
    match_flag_clr = cm;
    @(posedge clk);
    #1;
    r_en           = 1'b0;
    top_flag_clr   = 1'b0;
    match_flag_clr = 2'b00;
  endtask

  task automatic rdf(input logic [3:0] off, input logic [7:0] exp, input logic et,
                     input logic [1:0] em, input string name);
    rdfc(off, exp, et, em, 1'b0, 2'b00, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int hi0, hi1, exp_hi0;
    rst = 1'b1; address = '0; din = '0; w_en = 1'b0; r_en = 1'b0;
    top_flag_clr = 1'b0; match_flag_clr = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dout", {8'h00, dout}, 16'h0000);
    chk("rst_top", {15'd0, top_flag}, 16'd0);
    chk("rst_match", {14'd0, match_flag}, 16'd0);
    chk("rst_pwm", {14'd0, pwm_out}, 16'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Readback and unimplemented offsets
    wr(4'h4, 8'hA5);
    rd(4'h4, 8'hA5, "top_l_rb");
    rd(4'h5, 8'h00, "top_h_rb");
    rd(4'h0, 8'h00, "ctrl_rb");
    wr(4'hA, 8'hFF);
    rd(4'hA, 8'h00, "unimpl_a");

    // Free-run wrap, TOP=3, PS=0; MATCH0/1 are 0 so both fire on the count=0 tick
    wr(4'h4, 8'h03);
    wr(4'h0, 8'h01);
    rd(4'h2, 8'h00, "run_c0");
    rd(4'h2, 8'h01, "run_c1");
    rdf(4'h2, 8'h02, 1'b0, 2'b11, "run_c2");
    rdf(4'h2, 8'h03, 1'b1, 2'b11, "run_c3");
    rd(4'h2, 8'h00, "run_wrap");
    wr(4'h0, 8'h00);
    rdf(4'hF, 8'h00, 1'b1, 2'b11, "top_sticky");
    rdfc(4'hF, 8'h00, 1'b0, 2'b11, 1'b1, 2'b00, "top_clr_port");
    rd(4'h2, 8'h02, "run_hold");
    rd(4'h3, 8'h00, "run_hold_h");

    // Prescale by 4, TOP=9, MATCH0=4
    wr(4'h1, 8'h07);
    rdf(4'hF, 8'h00, 1'b0, 2'b00, "st_clr_all");
    wr(4'h4, 8'h09);
    wr(4'h6, 8'h04);
    wr(4'h3, 8'h00);
    wr(4'h2, 8'h00);
    wr(4'h0, 8'h09);
    idle(2);
    rdf(4'hF, 8'h00, 1'b0, 2'b00, "ps_pretick");
    rdf(4'hF, 8'h00, 1'b0, 2'b10, "ps_m1_fire");
    rd(4'h2, 8'h01, "ps_c1");
    idle(13);
    rdf(4'h2, 8'h04, 1'b0, 2'b10, "ps_c4");
    rdf(4'hF, 8'h00, 1'b0, 2'b11, "ps_m0_fire");

    // Set/clear collision with TOP=0: every cycle sets all flags
    wr(4'h0, 8'h00);
    wr(4'h4, 8'h00);
    wr(4'h6, 8'h00);
    wr(4'h3, 8'h00);
    wr(4'h2, 8'h00);
    wr(4'h0, 8'h01);
    rdfc(4'hF, 8'h00, 1'b1, 2'b11, 1'b0, 2'b01, "collide_set_wins");
    wr(4'h0, 8'h00);
    wr(4'h1, 8'h02);
    rdf(4'hF, 8'h00, 1'b1, 2'b10, "st_w1c_m0");
    wr(4'h1, 8'h00);
    rdf(4'h1, 8'h05, 1'b1, 2'b10, "st_w0_noop");
    rdfc(4'hF, 8'h00, 1'b1, 2'b00, 1'b0, 2'b10, "clr_port_m1");

    // One-shot with 16-bit TOP=0x0102
    wr(4'h1, 8'h07);
    wr(4'h4, 8'h02);
    wr(4'h5, 8'h01);
    wr(4'h6, 8'hFF);
    wr(4'h7, 8'hFF);
    wr(4'h3, 8'h00);
    wr(4'h2, 8'h00);
    wr(4'h0, 8'h03);
    idle(300);
    rdf(4'h0, 8'h02, 1'b1, 2'b10, "os_en_off");
    rd(4'h2, 8'h00, "os_cnt_l");
    rd(4'h3, 8'h00, "os_cnt_h");
    rd(4'h5, 8'h01, "os_top_h");
    wr(4'h1, 8'h01);
    idle(10);
    rdf(4'hF, 8'h00, 1'b0, 2'b10, "os_once");
    wr(4'h3, 8'h12);
    wr(4'h2, 8'h34);
    rd(4'h2, 8'h34, "atomic_l");
    rd(4'h3, 8'h12, "atomic_h");
    wr(4'h3, 8'h56);
    rd(4'h2, 8'h34, "hi_only_l");
    rd(4'h3, 8'h12, "hi_only_h");

    // Unselected addresses
    rda(16'h0022, 8'h00, "unsel_22");
    rda(16'h0002, 8'h00, "unsel_02");

    // PWM: TOP=7, MATCH0=3 -> 3 of 8 cycles; MATCH1=0 -> never
    wr(4'h4, 8'h07);
    wr(4'h5, 8'h00);
    wr(4'h6, 8'h03);
    wr(4'h7, 8'h00);
    wr(4'h3, 8'h00);
    wr(4'h2, 8'h00);
    wr(4'h0, 8'h01);
    idle(8);
    hi0 = 0;
    hi1 = 0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      hi0 += int'(pwm_out[0]);
      hi1 += int'(pwm_out[1]);
    end
`ifdef TIMER_MULTI_PWM_EN
    exp_hi0 = 12;
`else
    exp_hi0 = 0;
`endif
    chk("pwm0_duty", 16'(hi0), 16'(exp_hi0));
    chk("pwm1_zero", 16'(hi1), 16'd0);

    // Asynchronous reset while running with count=5 and flags set
    wr(4'h0, 8'h00);
    wr(4'h4, 8'h20);
    wr(4'h5, 8'h00);
    wr(4'h3, 8'h00);
    wr(4'h2, 8'h05);
    wr(4'h0, 8'h3D);
    rdf(4'h2, 8'h05, 1'b1, 2'b11, "pre_rst_cnt");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_dout", {8'h00, dout}, 16'h0000);
    chk("async_top", {15'd0, top_flag}, 16'd0);
    chk("async_match", {14'd0, match_flag}, 16'd0);
    chk("async_pwm", {14'd0, pwm_out}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd(4'h2, 8'h00, "post_rst_cnt");
    rd(4'h0, 8'h00, "post_rst_ctrl");
    rd(4'h4, 8'h00, "post_rst_top");
    rdf(4'hF, 8'h00, 1'b0, 2'b00, "post_rst_flags");
    idle(3);
    chk("sb_drain", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
